// File: rtl/uart_rx_sched.sv
// rtl/uart_rx_sched.sv - UART receive scheduler: receiver gating, frame timeout, byte FIFO, sticky status
// Optional feature macro: UART_RX_SCHED_BYTECNT_EN adds a saturating byte_count output.
module uart_rx_sched #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1760
) (
  input  logic                     MHz10,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic                     rx_begin,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  output logic                     rx_en,
  output logic                     rx_abort,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     timeout,
`ifdef UART_RX_SCHED_BYTECNT_EN
  output logic [15:0]              byte_count,
`endif
  input  logic                     clear_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rx_en_q, rx_en_d;
  logic             rx_abort_q, rx_abort_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic wr_ok;
  logic drop;

  // Frame tracking: enable=0 forces OFF ahead of every other transition; timer only runs in BUSY.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    push       = 1'b0;
    rx_abort_d = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_done) begin
            push = 1'b1;
          end
          if (rx_begin) begin
            state_d = ST_BUSY;
            timer_d = '0;
          end
        end
        ST_BUSY: begin
          timer_d = timer_q + TMR_W'(1);
          if (rx_done) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else if (timer_q == TMR_LAST) begin
            state_d    = ST_IDLE;
            rx_abort_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
    rx_en_d = (state_d != ST_OFF);
  end

  // FIFO bookkeeping: a push into a full FIFO only lands if a pop frees the head slot in the same cycle.
  always_comb begin
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == CNT_FULL);
    wr_ok    = push && (!full || pop);
    drop     = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flags: a new error in the same cycle as clear_err keeps the flag set.
  always_comb begin
    overflow_d = (overflow_q && !clear_err) || drop;
    timeout_d  = (timeout_q && !clear_err) || rx_abort_d;
  end

  // State, FIFO and flag registers.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_OFF;
      timer_q    <= '0;
      rx_en_q    <= 1'b0;
      rx_abort_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rx_en_q    <= rx_en_d;
      rx_abort_q <= rx_abort_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef UART_RX_SCHED_BYTECNT_EN
  logic [15:0] byte_count_q, byte_count_d;

  // Saturating count of bytes actually stored; dropped bytes are not counted.
  always_comb begin
    byte_count_d = byte_count_q;
    if (clear_err) begin
      byte_count_d = 16'h0000;
    end else if (wr_ok && (byte_count_q != 16'hFFFF)) begin
      byte_count_d = byte_count_q + 16'd1;
    end
  end

  // Byte counter register.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      byte_count_q <= 16'h0000;
    end else begin
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_count = byte_count_q;
`endif

  // When empty, rd_ptr equals wr_ptr, so the most recently written byte sits one slot behind.
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : mem_q[rd_ptr_q - PTR_W'(1)];
  assign fifo_count = count_q;
  assign rx_en      = rx_en_q;
  assign rx_abort   = rx_abort_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_rx_sched.sv
// tb/tb_uart_rx_sched.sv - randomized and directed self-checking bench for uart_rx_sched
module tb_uart_rx_sched;

  localparam int DEPTH = 4;
  localparam int TO    = 1760;

  logic       MHz10     = 1'b0;
  logic       nrst      = 1'b0;
  logic       enable    = 1'b0;
  logic       rx_begin  = 1'b0;
  logic       rx_done   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       out_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic       rx_en;
  logic       rx_abort;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;
`ifdef UART_RX_SCHED_BYTECNT_EN
  logic [15:0] byte_count;
`endif

  uart_rx_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .MHz10      (MHz10),
    .nrst       (nrst),
    .enable     (enable),
    .rx_begin   (rx_begin),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .rx_abort   (rx_abort),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .timeout    (timeout),
`ifdef UART_RX_SCHED_BYTECNT_EN
    .byte_count (byte_count),
`endif
    .clear_err  (clear_err)
  );

  always #50 MHz10 = ~MHz10;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: receiver on/off, frame-in-progress with start cycle, byte queue.
  int         cyc     = 0;
  bit         m_on    = 0;
  bit         m_frame = 0;
  int         m_start = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_last  = 8'h00;
  bit         m_ovf   = 0;
  bit         m_tmo   = 0;
  bit         m_abort = 0;
  int         m_bc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_frame = 0; m_start = 0; m_q.delete(); m_last = 8'h00;
    m_ovf = 0; m_tmo = 0; m_abort = 0; m_bc = 0;
  endtask

  task automatic model_edge();
    bit pop, push, wr, drop, abrt;
    pop  = (m_q.size() > 0) && out_ready;
    push = 0;
    abrt = 0;
    if (!enable) begin
      m_on = 0; m_frame = 0;
    end else if (!m_on) begin
      m_on = 1;
    end else if (m_frame) begin
      if (rx_done) begin
        push = 1; m_frame = 0;
      end else if (cyc - m_start == TO) begin
        abrt = 1; m_frame = 0;
      end
    end else begin
      if (rx_done) push = 1;
      if (rx_begin) begin
        m_frame = 1; m_start = cyc;
      end
    end
    drop = push && (m_q.size() == DEPTH) && !pop;
    wr   = push && !drop;
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      m_q.push_back(rx_data);
      m_last = rx_data;
    end
    m_ovf   = (m_ovf && !clear_err) || drop;
    m_tmo   = (m_tmo && !clear_err) || abrt;
    m_abort = abrt;
    if (clear_err) m_bc = 0;
    else if (wr && m_bc < 65535) m_bc++;
  endtask

  task automatic compare_all();
    check("rx_en", rx_en, m_on);
    check("rx_abort", rx_abort, m_abort);
    check("out_valid", out_valid, m_q.size() > 0);
    check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : m_last);
    check("fifo_count", fifo_count, m_q.size());
    check("overflow", overflow, m_ovf);
    check("timeout", timeout, m_tmo);
`ifdef UART_RX_SCHED_BYTECNT_EN
    check("byte_count", byte_count, m_bc);
`endif
  endtask

  task automatic tick();
    @(posedge MHz10);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic frame(input logic [7:0] d);
    rx_begin = 1; tick(); rx_begin = 0;
    tick(); tick();
    rx_done = 1; rx_data = d; tick(); rx_done = 0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, out_data, d);
    out_ready = 1; tick(); out_ready = 0;
  endtask

  initial begin
    logic [7:0] exp3 [4];
    #20;
    model_reset();
    compare_all();
    check("rst_rx_en", rx_en, 0);
    check("rst_count", fifo_count, 0);
    #40 nrst = 1;

    // 1: single frame then pop
    enable = 1; tick();
    check("s1_rx_en", rx_en, 1);
    frame(8'hA5);
    check("s1_valid", out_valid, 1);
    check("s1_data", out_data, 8'hA5);
    check("s1_count", fifo_count, 1);
    out_ready = 1; tick(); out_ready = 0;
    check("s1_count_pop", fifo_count, 0);
    check("s1_valid_pop", out_valid, 0);

    // 2: overflow with five frames
    for (int i = 1; i <= 5; i++) frame(8'(i));
    check("s2_count", fifo_count, 4);
    check("s2_ovf", overflow, 1);
    for (int i = 1; i <= 4; i++) pop_expect("s2_pop", 8'(i));
    check("s2_empty", fifo_count, 0);
    clear_err = 1; tick(); clear_err = 0;
    check("s2_ovf_clr", overflow, 0);

    // 3: push coincides with pop while full
    for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i));
    rx_begin = 1; tick(); rx_begin = 0;
    rx_done = 1; rx_data = 8'h77; out_ready = 1; tick();
    rx_done = 0; out_ready = 0;
    check("s3_count", fifo_count, 4);
    check("s3_ovf", overflow, 0);
    exp3[0] = 8'h12; exp3[1] = 8'h13; exp3[2] = 8'h14; exp3[3] = 8'h77;
    for (int i = 0; i < 4; i++) pop_expect("s3_pop", exp3[i]);

    // 4: frame timeout
    frame(8'h5A);
    rx_begin = 1; tick(); rx_begin = 0;
    repeat (TO - 1) tick();
    check("s4_abort_early", rx_abort, 0);
    tick();
    check("s4_abort", rx_abort, 1);
    check("s4_tmo", timeout, 1);
    check("s4_count", fifo_count, 1);
    tick();
    check("s4_abort_once", rx_abort, 0);
    rx_done = 1; rx_data = 8'h6B; tick(); rx_done = 0;
    check("s4_idle_push", fifo_count, 2);
    clear_err = 1; tick(); clear_err = 0;
    check("s4_tmo_clr", timeout, 0);
    out_ready = 1; tick(); tick(); out_ready = 0;

    // 5: disable mid-frame
    frame(8'h21); frame(8'h22);
    rx_begin = 1; tick(); rx_begin = 0;
    enable = 0; tick();
    check("s5_rx_en_off", rx_en, 0);
    rx_done = 1; rx_data = 8'h99; tick(); rx_done = 0;
    check("s5_ignored", fifo_count, 2);
    enable = 1; tick();
    check("s5_rx_en_on", rx_en, 1);
    pop_expect("s5_pop", 8'h21);
    pop_expect("s5_pop", 8'h22);

    // 6: asynchronous reset while busy
    frame(8'h31); frame(8'h32);
    rx_begin = 1; tick(); rx_begin = 0;
    #20 nrst = 0;
    #1;
    model_reset();
    compare_all();
    check("s6_count", fifo_count, 0);
    check("s6_rx_en", rx_en, 0);
    @(negedge MHz10) nrst = 1;
    tick();
    frame(8'h41);
    check("s6_count_after", fifo_count, 1);
`ifdef UART_RX_SCHED_BYTECNT_EN
    check("s6_bytecnt", byte_count, 1);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 31) != 0);
      rx_begin  = ($urandom_range(0, 5) == 0);
      rx_done   = ($urandom_range(0, 4) == 0);
      rx_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      clear_err = ($urandom_range(0, 39) == 0);
      tick();
    end
    enable = 1; rx_begin = 0; rx_done = 0; clear_err = 0; out_ready = 1;
    repeat (6) tick();
    check("final_empty", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_sched.md
Name: uart_rx_sched

Overview:
Receive-side controller for the 10 MHz UART receiver. It gates the receiver's enable, tracks each frame from start-edge to done, and guards against hung frames with a timeout. Completed bytes are buffered in a small FIFO, and a ready/valid interface hands them to the downstream consumer (command decoder / team logic). Sticky overflow and timeout flags are exported for status polling.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 1760, max clock cycles from frame start to done (11 bit times × 160)

Ports:
MHz10  in  1  system clock, 10 MHz
nrst  in  1  reset, asynchronous, active-low
enable  in  1  block enable from top-level
rx_begin  in  1  receiver start-edge pulse
rx_done  in  1  receiver frame-complete pulse, one cycle
rx_data  in  8  receiver parallel byte, valid when rx_done=1
rx_en  out  1  enable to receiver, registered
rx_abort  out  1  one-cycle pulse on timeout; receiver/top returns to idle
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head byte
fifo_count  out  $clog2(DEPTH)+1  number of stored bytes
overflow  out  1  sticky: byte dropped because FIFO full
timeout  out  1  sticky: frame timed out
clear_err  in  1  clears overflow and timeout

Behaviour:
- Reset: state OFF; all outputs 0; FIFO empty; timer 0.
- FSM states:
  - OFF: rx_en=0.
  - IDLE: rx_en=1.
  - BUSY: rx_en=1; a frame is in progress.
- Transitions:
  - OFF→IDLE when enable=1. rx_en rises on the following edge.
  - Any state→OFF when enable=0. This takes priority over all other transitions. FIFO contents and flags are retained, and popping continues while OFF.
  - IDLE→BUSY on rx_begin=1. Timer cleared to 0.
  - BUSY: timer increments by 1 per cycle.
    - rx_done=1 → push rx_data, go to IDLE.
    - Otherwise, timer==TIMEOUT_CYCLES-1 → IDLE, timeout←1, rx_abort=1 for exactly one cycle, no push.
  - rx_done while IDLE: byte pushed, state stays IDLE. rx_done while OFF is ignored.
  - rx_begin while BUSY is ignored.
- FIFO:
  - Circular buffer with read and write pointers of width $clog2(DEPTH). Pointers wrap naturally from DEPTH-1 to 0.
  - out_data is read combinationally from the entry at the read pointer; undefined-free (value of last-written entry) when empty.
  - Pop = out_valid & out_ready. Push = accepted rx_done.
  - Push when full with no pop in the same cycle: byte dropped, overflow←1, count unchanged.
  - Push and pop in the same cycle when full: both occur, count stays DEPTH, no overflow.
  - Push and pop in the same cycle when non-empty and not full: count unchanged.
  - When empty: out_valid=0, so a pop is impossible and out_ready is ignored.
- Latency: rx_done at edge N → out_valid=1 and fifo_count updated after edge N+1.
- clear_err=1 clears both flags on the next edge. If a new error event occurs in the same cycle, the error wins (flag stays 1).
- Reset asserted mid-frame returns everything to the reset state immediately and asynchronously; FIFO contents are lost.

Optional Feature:
Macro UART_RX_SCHED_BYTECNT_EN.
- Defined: adds output byte_count [15:0], a saturating count of bytes successfully pushed. It holds at 16'hFFFF once reached and is cleared by nrst and by clear_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then enable=1 → rx_en=1 after one edge. Pulse rx_begin, then rx_done with rx_data=8'hA5 → out_valid=1, out_data=8'hA5, fifo_count=1. Assert out_ready one cycle → fifo_count=0, out_valid=0.
2. Five frames 8'h01..8'h05 with out_ready=0, DEPTH=4 → fifo_count=4 and overflow=1. Popping yields 01,02,03,04; 05 is dropped.
3. FIFO full; rx_done (8'h77) coincides with a pop → fifo_count stays 4, overflow=0. Last popped byte is 8'h77.
4. rx_begin with no rx_done for 1760 cycles → rx_abort high exactly at cycle 1760, timeout=1, state IDLE, fifo_count unchanged. clear_err → timeout=0.
5. Mid-frame (BUSY), drop enable → rx_en=0 next edge; a later rx_done is ignored. Re-enable → IDLE, and stored bytes are still poppable in order.
6. Assert nrst low while BUSY with 2 bytes stored → all outputs 0 immediately, fifo_count=0. With UART_RX_SCHED_BYTECNT_EN, byte_count=0 after reset and increments per push.
